// File: rtl/ls_unit.sv
// Load/store execution unit: takes one memory op from the LS queue head,
// drives a single-port data memory and reports completion/load results.
module ls_unit #(
    parameter int XLEN        = 32,
    parameter int ROB_TAG_LEN = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   req_valid,
    input  logic                   req_read,
    input  logic [ROB_TAG_LEN-1:0] req_rob_tag,
    input  logic [XLEN-1:0]        req_base,
    input  logic [XLEN-1:0]        req_data,
    input  logic [XLEN-1:0]        req_imm,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    output logic                   busy,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_wr_en,
    output logic [XLEN-1:0]        mem_addr,
    output logic [3:0]             mem_byte_en,
    output logic [XLEN-1:0]        mem_wdata,
    input  logic                   mem_resp_valid,
    input  logic [XLEN-1:0]        mem_rdata,
    output logic                   done,
    output logic                   cdb_valid,
    output logic [ROB_TAG_LEN-1:0] cdb_tag,
    output logic [XLEN-1:0]        cdb_data,
    output logic                   exc_misalign
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t                 state_q;
    logic                   read_q, unsigned_q, kill_q;
    logic [1:0]             size_q, off_q;
    logic [ROB_TAG_LEN-1:0] tag_q;
    logic                   mem_req_valid_q, mem_wr_en_q;
    logic [XLEN-1:0]        mem_addr_q, mem_wdata_q;
    logic [3:0]             mem_byte_en_q;
    logic                   done_q, cdb_valid_q, exc_q;
    logic [ROB_TAG_LEN-1:0] cdb_tag_q;
    logic [XLEN-1:0]        cdb_data_q;

    logic [XLEN-1:0] addr_d, wdata_d, shifted_d, ext_d;
    logic [3:0]      be_d;
    logic            mis_d;

    assign addr_d = req_base + req_imm;

    always_comb begin
        mis_d   = 1'b0;
        be_d    = 4'b1111;
        wdata_d = req_data;
        unique case (req_size)
            2'b00: begin
                be_d    = 4'b0001 << addr_d[1:0];
                wdata_d = {4{req_data[7:0]}};
            end
            2'b01: begin
                mis_d   = addr_d[0];
                be_d    = addr_d[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{req_data[15:0]}};
            end
            2'b10: mis_d = |addr_d[1:0];
            default: mis_d = 1'b1;
        endcase
    end

    assign shifted_d = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        ext_d = shifted_d;
        unique case (size_q)
            2'b00: ext_d = {{(XLEN-8){~unsigned_q & shifted_d[7]}},
                            shifted_d[7:0]};
            2'b01: ext_d = {{(XLEN-16){~unsigned_q & shifted_d[15]}},
                            shifted_d[15:0]};
            default: ext_d = shifted_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            read_q          <= 1'b0;
            unsigned_q      <= 1'b0;
            kill_q          <= 1'b0;
            size_q          <= 2'b00;
            off_q           <= 2'b00;
            tag_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_wr_en_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_byte_en_q   <= 4'b0000;
            mem_wdata_q     <= '0;
            done_q          <= 1'b0;
            cdb_valid_q     <= 1'b0;
            exc_q           <= 1'b0;
            cdb_tag_q       <= '0;
            cdb_data_q      <= '0;
        end else begin
            done_q      <= 1'b0;
            cdb_valid_q <= 1'b0;
            exc_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid && !flush) begin
                        read_q        <= req_read;
                        unsigned_q    <= req_unsigned;
                        size_q        <= req_size;
                        off_q         <= addr_d[1:0];
                        tag_q         <= req_rob_tag;
                        kill_q        <= 1'b0;
                        mem_wr_en_q   <= ~req_read;
                        mem_addr_q    <= {addr_d[XLEN-1:2], 2'b00};
                        mem_byte_en_q <= be_d;
                        mem_wdata_q   <= wdata_d;
                        if (mis_d) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            exc_q       <= 1'b1;
                            cdb_valid_q <= req_read;
                            cdb_tag_q   <= req_rob_tag;
                            cdb_data_q  <= '0;
                        end else begin
                            state_q         <= REQ;
                            mem_req_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (flush && read_q) begin
                        state_q         <= IDLE;
                        mem_req_valid_q <= 1'b0;
                    end else begin
                        // A flushed store is already committed; finish it silently.
                        if (flush) kill_q <= 1'b1;
                        if (mem_req_ready) begin
                            state_q         <= WAIT;
                            mem_req_valid_q <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        if (kill_q || flush) begin
                            state_q <= IDLE;
                        end else begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            cdb_valid_q <= read_q;
                            if (read_q) begin
                                cdb_tag_q  <= tag_q;
                                cdb_data_q <= ext_d;
                            end
                        end
                    end else if (flush) begin
                        if (read_q) state_q <= DRAIN;
                        else        kill_q  <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                DRAIN: begin
                    if (mem_resp_valid) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = (state_q != IDLE);
    assign mem_req_valid = mem_req_valid_q;
    assign mem_wr_en     = mem_wr_en_q;
    assign mem_addr      = mem_addr_q;
    assign mem_byte_en   = mem_byte_en_q;
    assign mem_wdata     = mem_wdata_q;
    assign done          = done_q & ~flush;
    assign cdb_valid     = cdb_valid_q & ~flush;
    assign cdb_tag       = cdb_tag_q;
    assign cdb_data      = cdb_data_q;
    assign exc_misalign  = exc_q & ~flush;

endmodule

// File: tb/tb_ls_unit.sv
// Directed testbench for ls_unit: loads, stores, misalignment, flush
// and reset scenarios with hand-computed expectations.
module tb_ls_unit;

    logic        clk, reset, flush;
    logic        req_valid, req_read, req_unsigned;
    logic [4:0]  req_rob_tag;
    logic [31:0] req_base, req_data, req_imm;
    logic [1:0]  req_size;
    logic        busy, mem_req_valid, mem_req_ready, mem_wr_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, cdb_data;
    logic [3:0]  mem_byte_en;
    logic        mem_resp_valid, done, cdb_valid, exc_misalign;
    logic [4:0]  cdb_tag;

    int checks = 0;
    int errors = 0;

    ls_unit #(.XLEN(32), .ROB_TAG_LEN(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_read(req_read),
        .req_rob_tag(req_rob_tag), .req_base(req_base),
        .req_data(req_data), .req_imm(req_imm),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .busy(busy), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_byte_en(mem_byte_en),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata), .done(done), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .exc_misalign(exc_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    // Presents one op for a single capture edge, then withdraws req_valid.
    task automatic issue(input logic rd, input logic [4:0] tag,
                         input logic [31:0] base, input logic [31:0] imm,
                         input logic [31:0] data, input logic [1:0] size,
                         input logic uns);
        req_read = rd; req_rob_tag = tag; req_base = base;
        req_imm = imm; req_data = data; req_size = size;
        req_unsigned = uns; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; req_read = 1'b0;
        req_rob_tag = '0; req_base = '0; req_data = '0; req_imm = '0;
        req_size = 2'b00; req_unsigned = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_rdata = '0;
        tick(); tick(); tick();
        checks++;
        if ({busy, mem_req_valid, mem_wr_en, done, cdb_valid, exc_misalign}
            !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000",
                {busy, mem_req_valid, mem_wr_en, done, cdb_valid, exc_misalign});
        end
        checks++;
        if ({mem_addr, mem_byte_en, mem_wdata, cdb_tag, cdb_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%h be=%b wd=%h tag=%h d=%h required 0",
                mem_addr, mem_byte_en, mem_wdata, cdb_tag, cdb_data);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        mem_req_ready = 1'b1;
        issue(1'b1, 5'd9, 32'h100, 32'h4, 32'h0, 2'b10, 1'b0);
        checks++;
        if ({mem_req_valid, mem_wr_en, busy} !== 3'b101) begin
            errors++;
            $display("FAIL lw_req: valid/wr/busy=%b required 101",
                {mem_req_valid, mem_wr_en, busy});
        end
        checks++;
        if (mem_addr !== 32'h104 || mem_byte_en !== 4'b1111) begin
            errors++;
            $display("FAIL lw_addr: addr=%h be=%b required 104/1111",
                mem_addr, mem_byte_en);
        end
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        checks++;
        if (mem_req_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL lw_wait: valid=%b done=%b required 0/0",
                mem_req_valid, done);
        end
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if ({done, cdb_valid, exc_misalign} !== 3'b110 ||
            cdb_data !== 32'hDEADBEEF || cdb_tag !== 5'd9) begin
            errors++;
            $display("FAIL lw_done: d/c/e=%b data=%h tag=%0d required 110/deadbeef/9",
                {done, cdb_valid, exc_misalign}, cdb_data, cdb_tag);
        end
        tick();
        checks++;
        if (done !== 1'b0 || cdb_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL lw_idle: done=%b cdb=%b busy=%b required 0",
                done, cdb_valid, busy);
        end
    endtask

    task automatic test_lb_lbu();
        for (int k = 0; k < 2; k++) begin
            mem_req_ready = 1'b1;
            issue(1'b1, 5'd3, 32'h100, 32'h3, 32'h0, 2'b00, k[0]);
            checks++;
            if (mem_byte_en !== 4'b1000 || mem_addr !== 32'h100) begin
                errors++;
                $display("FAIL lb_lane%0d: be=%b addr=%h required 1000/100",
                    k, mem_byte_en, mem_addr);
            end
            tick();
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b1; mem_rdata = 32'h80123456;
            tick();
            mem_resp_valid = 1'b0;
            checks++;
            if (cdb_valid !== 1'b1 ||
                cdb_data !== (k == 0 ? 32'hFFFFFF80 : 32'h00000080)) begin
                errors++;
                $display("FAIL lb_data%0d: cdb=%b data=%h required 1/%h", k,
                    cdb_valid, cdb_data, (k == 0 ? 32'hFFFFFF80 : 32'h80));
            end
            tick();
        end
    endtask

    task automatic test_sh_stall();
        mem_req_ready = 1'b0;
        issue(1'b0, 5'd4, 32'h200, 32'h2, 32'h1234ABCD, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_wr_en !== 1'b1 ||
                mem_addr !== 32'h200 || mem_byte_en !== 4'b1100 ||
                mem_wdata !== 32'hABCDABCD) begin
                errors++;
                $display("FAIL sh_hold%0d: v=%b w=%b a=%h be=%b wd=%h", i,
                    mem_req_valid, mem_wr_en, mem_addr, mem_byte_en, mem_wdata);
            end
            if (i == 3) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL sh_wait: valid=%b cdb=%b required 0/0",
                mem_req_valid, cdb_valid);
        end
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || cdb_valid !== 1'b0 || exc_misalign !== 1'b0) begin
            errors++;
            $display("FAIL sh_done: done=%b cdb=%b exc=%b required 1/0/0",
                done, cdb_valid, exc_misalign);
        end
        tick();
    endtask

    task automatic test_misalign();
        issue(1'b1, 5'd7, 32'h100, 32'h1, 32'h0, 2'b10, 1'b0);
        checks++;
        if (mem_req_valid !== 1'b0 ||
            {done, exc_misalign, cdb_valid} !== 3'b111 ||
            cdb_data !== 32'h0 || cdb_tag !== 5'd7) begin
            errors++;
            $display("FAIL mis_lw: v=%b d/e/c=%b data=%h tag=%0d required 0/111/0/7",
                mem_req_valid, {done, exc_misalign, cdb_valid}, cdb_data, cdb_tag);
        end
        tick();
        issue(1'b0, 5'd2, 32'h200, 32'h1, 32'h55, 2'b01, 1'b0);
        checks++;
        if (mem_req_valid !== 1'b0 ||
            {done, exc_misalign, cdb_valid} !== 3'b110) begin
            errors++;
            $display("FAIL mis_sh: v=%b d/e/c=%b required 0/110",
                mem_req_valid, {done, exc_misalign, cdb_valid});
        end
        tick();
        issue(1'b1, 5'd1, 32'h300, 32'h0, 32'h0, 2'b11, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || cdb_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_rsv_flush: done=%b cdb=%b v=%b required 0",
                done, cdb_valid, mem_req_valid);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mis_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_flush_wait();
        mem_req_ready = 1'b1;
        issue(1'b1, 5'd5, 32'h300, 32'h0, 32'h0, 2'b10, 1'b0);
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || cdb_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain%0d: busy=%b done=%b cdb=%b required 1/0/0",
                    i, busy, done, cdb_valid);
            end
            if (i == 1) begin
                mem_resp_valid = 1'b1; mem_rdata = 32'h11112222;
            end
            tick();
        end
        mem_resp_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: busy=%b done=%b cdb=%b required 0",
                busy, done, cdb_valid);
        end
        mem_req_ready = 1'b1;
        issue(1'b1, 5'd6, 32'h400, 32'h8, 32'h0, 2'b01, 1'b1);
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h408 ||
            mem_byte_en !== 4'b0011) begin
            errors++;
            $display("FAIL drain_next: v=%b addr=%h be=%b required 1/408/0011",
                mem_req_valid, mem_addr, mem_byte_en);
        end
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_rdata = 32'h0000F00D;
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || cdb_data !== 32'h0000F00D || cdb_tag !== 5'd6) begin
            errors++;
            $display("FAIL lhu_done: done=%b data=%h tag=%0d required 1/f00d/6",
                done, cdb_data, cdb_tag);
        end
        tick();
    endtask

    task automatic test_flush_store();
        mem_req_ready = 1'b0;
        req_read = 1'b0; req_rob_tag = 5'd12; req_base = 32'h400;
        req_imm = 32'h0; req_data = 32'hCAFEF00D; req_size = 2'b10;
        req_unsigned = 1'b0; req_valid = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_wr_en !== 1'b1 ||
            mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h400) begin
            errors++;
            $display("FAIL sw_flush_req: v=%b w=%b wd=%h a=%h required 1/1/cafef00d/400",
                mem_req_valid, mem_wr_en, mem_wdata, mem_addr);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        checks++;
        if (mem_req_valid !== 1'b0 || busy !== 1'b1 || mem_addr !== 32'h400) begin
            errors++;
            $display("FAIL sw_flush_wait: v=%b busy=%b a=%h required 0/1/400",
                mem_req_valid, busy, mem_addr);
        end
        mem_resp_valid = 1'b1;
        req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL sw_flush_end: done=%b busy=%b cdb=%b required 0",
                done, busy, cdb_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sw_flush_after: done=%b busy=%b required 0", done, busy);
        end
    endtask

    task automatic test_reset_midop();
        mem_req_ready = 1'b0;
        issue(1'b1, 5'd8, 32'h500, 32'h0, 32'h0, 2'b10, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_midop: busy=%b v=%b a=%h required 0/0/0",
                busy, mem_req_valid, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_stall();
        test_misalign();
        test_flush_wait();
        test_flush_store();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
